register_file_mp: RTL and testbench

- Parametrised multi-port general-purpose register file for the MIPS datapath.
- Successor to the single-write, two-read register file, generalised in width, depth, read-port count and write-port count.
- Adds registered reads with write-first bypass, deterministic hardware clear after reset, and defined write-collision priority.
- Sits between decode (read addresses) and writeback (write ports).

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_clear_seq.sv | 73 +++++++
 rtl/register_file_mp.sv | 159 +++++++++++++++
 tb/tb_register_file_mp.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and types for the multi-port MIPS register file.
//   - REGFILE_DATA_W / REGFILE_DEPTH : default register width and count
//   - regfile_state_e                : clear-sequencer state encoding
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_DEPTH  = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } regfile_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// ---------------------------------------------------------------------------
// regfile_clear_seq
//   Post-reset clear sequencer. After reset it walks every register address
//   once, requesting a zero write per cycle, then settles in RUN until the
//   next reset.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   CLEAR | zeroing REGS[ptr] each cycle; user writes/reads blocked
//   RUN   | normal operation; only a reset returns to CLEAR
//
// Ports:
//   CLOCK      in   clock, all updates on posedge
//   RESET_N    in   synchronous active-low reset
//   clear_we   out  request a zero write to clear_addr this cycle
//   clear_addr out  address being cleared (ADDR_W bits)
//   busy       out  high while in CLEAR
// ---------------------------------------------------------------------------
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH  = REGFILE_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  regfile_state_e    state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    clear_we  = 1'b0;
    case (state)
      ST_CLEAR: begin
        clear_we = 1'b1;
        ptr_nxt  = ptr + ADDR_W'(1);
        if (ptr == LAST_ADDR) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_CLEAR;
      end
    endcase
  end

  // State is registered, so busy is a registered output that drops on the
  // same edge that enters RUN.
  assign busy       = (state == ST_CLEAR);
  assign clear_addr = ptr;

endmodule : regfile_clear_seq

// File: rtl/register_file_mp.sv
// ---------------------------------------------------------------------------
// register_file_mp
//   Parametrised multi-port general-purpose register file for the MIPS
//   datapath. Registered reads (1-cycle latency) with write-first bypass,
//   hardware clear of every entry after reset, and higher-index-wins
//   priority when two write ports hit the same address.
//
// Optional feature macro: REGFILE_ZERO_REG_EN
//   defined   -> address 0 reads as zero, writes to it are discarded
//   undefined -> address 0 is an ordinary register
//
// Ports:
//   CLOCK    in   clock, all updates on posedge
//   RESET_N  in   synchronous active-low reset
//   RA       in   NUM_RD*ADDR_W read addresses, port i at [i*ADDR_W +: ADDR_W]
//   RD       out  NUM_RD*DATA_W registered read data, port i at [i*DATA_W +: DATA_W]
//   WE       in   NUM_WR write enables
//   WA       in   NUM_WR*ADDR_W write addresses
//   WD       in   NUM_WR*DATA_W write data
//   BUSY     out  high while the post-reset clear runs
// ---------------------------------------------------------------------------
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int DEPTH  = REGFILE_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) (
  input  logic                     CLOCK,
  input  logic                     RESET_N,
  input  logic [NUM_RD*ADDR_W-1:0] RA,
  output logic [NUM_RD*DATA_W-1:0] RD,
  input  logic [NUM_WR-1:0]        WE,
  input  logic [NUM_WR*ADDR_W-1:0] WA,
  input  logic [NUM_WR*DATA_W-1:0] WD,
  output logic                     BUSY
);

  logic              clear_we;
  logic [ADDR_W-1:0] clear_addr;
  logic              busy;

  regfile_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .busy       (busy)
  );

  assign BUSY = busy;

  // Unpacked views of the packed port buses.
  logic [ADDR_W-1:0] ra_a [NUM_RD];
  logic [ADDR_W-1:0] wa_a [NUM_WR];
  logic [DATA_W-1:0] wd_a [NUM_WR];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_ra
    assign ra_a[i] = RA[i*ADDR_W +: ADDR_W];
  end

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wa
    assign wa_a[j] = WA[j*ADDR_W +: ADDR_W];
    assign wd_a[j] = WD[j*DATA_W +: DATA_W];
  end

  // Effective per-port write enable: only in RUN, and never to the
  // hardwired zero register when that feature is built in.
  logic [NUM_WR-1:0] we_eff;

  always_comb begin
    we_eff = '0;
    for (int j = 0; j < NUM_WR; j++) begin
`ifdef REGFILE_ZERO_REG_EN
      we_eff[j] = WE[j] & ~busy & (wa_a[j] != '0);
`else
      we_eff[j] = WE[j] & ~busy;
`endif
    end
  end

  // Per-row write decode. The clear sequencer owns the array while busy.
  // User ports are scanned in ascending order so the highest-index port
  // targeting a row is the one that lands.
  logic              row_we [DEPTH];
  logic [DATA_W-1:0] row_wd [DEPTH];

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      row_we[k] = 1'b0;
      row_wd[k] = '0;
    end
    if (clear_we) begin
      row_we[clear_addr] = 1'b1;
      row_wd[clear_addr] = '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (we_eff[j]) begin
          row_we[wa_a[j]] = 1'b1;
          row_wd[wa_a[j]] = wd_a[j];
        end
      end
    end
  end

  // Storage: one flop row per register. Reset leaves contents alone; the
  // clear sequence that follows is what zeroes them.
  logic [DATA_W-1:0] regs [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_row
    logic [DATA_W-1:0] q;

    always_ff @(posedge CLOCK) begin
      if (RESET_N && row_we[k]) begin
        q <= row_wd[k];
      end
    end

    assign regs[k] = q;
  end

  // Read path with write-first bypass. Ascending scan mirrors the write
  // priority, so a bypassed value equals what the array holds afterwards.
  logic [DATA_W-1:0] rd_nxt [NUM_RD];

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_nxt[i] = regs[ra_a[i]];
      for (int j = 0; j < NUM_WR; j++) begin
        if (we_eff[j] && (wa_a[j] == ra_a[i])) begin
          rd_nxt[i] = wd_a[j];
        end
      end
`ifdef REGFILE_ZERO_REG_EN
      if (ra_a[i] == '0) begin
        rd_nxt[i] = '0;
      end
`endif
    end
  end

  // RD is forced to zero in reset and for the whole clear, including the
  // edge that hands over to RUN.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N || busy) begin
      RD <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        RD[i*DATA_W +: DATA_W] <= rd_nxt[i];
      end
    end
  end

endmodule : register_file_mp

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic                     CLOCK = 1'b0;
  logic                     RESET_N;
  logic [NUM_RD*ADDR_W-1:0] RA;
  logic [NUM_RD*DATA_W-1:0] RD;
  logic [NUM_WR-1:0]        WE;
  logic [NUM_WR*ADDR_W-1:0] WA;
  logic [NUM_WR*DATA_W-1:0] WD;
  logic                     BUSY;

  always #5 CLOCK = ~CLOCK;

  register_file_mp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .RA      (RA),
    .RD      (RD),
    .WE      (WE),
    .WA      (WA),
    .WD      (WD),
    .BUSY    (BUSY)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: plain array of register values plus expected RD.
  logic [DATA_W-1:0] mem_m  [DEPTH];
  logic [DATA_W-1:0] exp_rd [NUM_RD];

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_wr(input int j, input bit en, input int a, input logic [DATA_W-1:0] d);
    WE[j] = en;
    WA[j*ADDR_W +: ADDR_W] = ADDR_W'(a);
    WD[j*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_ra(input int i, input int a);
    RA[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  function automatic logic [DATA_W-1:0] rd_port(input int i);
    return RD[i*DATA_W +: DATA_W];
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;
  endfunction

  // One RUN cycle: later write ports override earlier ones, reads see the
  // post-write value, address 0 pinned to zero when the feature is built.
  task automatic run_cycle();
    for (int i = 0; i < NUM_RD; i++) begin
      int a;
      logic [DATA_W-1:0] v;
      a = int'(RA[i*ADDR_W +: ADDR_W]);
      v = mem_m[a];
      for (int j = 0; j < NUM_WR; j++) begin
        int wa;
        wa = int'(WA[j*ADDR_W +: ADDR_W]);
        if (WE[j] && wa == a && !(ZR && wa == 0)) v = WD[j*DATA_W +: DATA_W];
      end
      if (ZR && a == 0) v = '0;
      exp_rd[i] = v;
    end
    for (int j = 0; j < NUM_WR; j++) begin
      int wa;
      wa = int'(WA[j*ADDR_W +: ADDR_W]);
      if (WE[j] && !(ZR && wa == 0)) mem_m[wa] = WD[j*DATA_W +: DATA_W];
    end
    tick();
  endtask

  task automatic test_reset();
    int n;
    int bad;
    RESET_N = 1'b0;
    WE = '0;
    WA = '0;
    WD = '0;
    RA = '0;
    set_wr(0, 1'b1, 5, 32'hDEAD_BEEF);
    set_ra(0, 5);
    set_ra(1, 5);
    tick();
    tick();
    tests++;
    if (BUSY !== 1'b1) begin
      fails++;
      $display("FAIL reset_busy: got %b expected 1", BUSY);
    end
    tests++;
    if (RD !== '0) begin
      fails++;
      $display("FAIL reset_rd: got %h expected 0", RD);
    end
    RESET_N = 1'b1;
    n = 0;
    bad = 0;
    while (BUSY === 1'b1 && n < 100) begin
      tick();
      n++;
      if (BUSY === 1'b1 && RD !== '0) bad++;
    end
    tests++;
    if (n != DEPTH) begin
      fails++;
      $display("FAIL clear_busy_len: got %0d cycles expected %0d", n, DEPTH);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL clear_rd_zero: got %0d nonzero cycles expected 0", bad);
    end
    model_clear();
    WE = '0;
    set_ra(0, 5);
    set_ra(1, 4);
    run_cycle();
    tests++;
    if (rd_port(0) !== 32'h0) begin
      fails++;
      $display("FAIL clear_drop_write: got %h expected 00000000", rd_port(0));
    end
  endtask

  task automatic test_basic_rw();
    set_wr(0, 1'b1, 3, 32'h1234_5678);
    set_ra(0, 1);
    set_ra(1, 2);
    run_cycle();
    WE = '0;
    set_ra(0, 3);
    set_ra(1, 4);
    run_cycle();
    tests++;
    if (rd_port(0) !== 32'h1234_5678) begin
      fails++;
      $display("FAIL basic_rd0: got %h expected 12345678", rd_port(0));
    end
    tests++;
    if (rd_port(1) !== 32'h0) begin
      fails++;
      $display("FAIL basic_rd1: got %h expected 00000000", rd_port(1));
    end
  endtask

  task automatic test_bypass();
    set_wr(0, 1'b1, 7, 32'hA5A5_A5A5);
    set_ra(0, 7);
    set_ra(1, 3);
    run_cycle();
    tests++;
    if (rd_port(0) !== 32'hA5A5_A5A5) begin
      fails++;
      $display("FAIL bypass_rd0: got %h expected a5a5a5a5", rd_port(0));
    end
    tests++;
    if (rd_port(1) !== exp_rd[1]) begin
      fails++;
      $display("FAIL bypass_rd1: got %h expected %h", rd_port(1), exp_rd[1]);
    end
  endtask

  task automatic test_collision();
    set_wr(0, 1'b1, 9, 32'h1);
    set_wr(1, 1'b1, 9, 32'h2);
    set_ra(0, 9);
    set_ra(1, 9);
    run_cycle();
    for (int i = 0; i < NUM_RD; i++) begin
      tests++;
      if (rd_port(i) !== 32'h2) begin
        fails++;
        $display("FAIL collision_bypass rd%0d: got %h expected 00000002", i, rd_port(i));
      end
    end
    WE = '0;
    run_cycle();
    tests++;
    if (rd_port(0) !== 32'h2) begin
      fails++;
      $display("FAIL collision_after: got %h expected 00000002", rd_port(0));
    end
  endtask

  task automatic test_zero_reg();
    logic [DATA_W-1:0] want;
    want = ZR ? 32'h0 : 32'hFFFF_FFFF;
    WE = '0;
    set_wr(0, 1'b1, 0, 32'hFFFF_FFFF);
    set_ra(0, 0);
    set_ra(1, 0);
    run_cycle();
    tests++;
    if (rd_port(0) !== want) begin
      fails++;
      $display("FAIL zero_reg_bypass: got %h expected %h", rd_port(0), want);
    end
    WE = '0;
    run_cycle();
    tests++;
    if (rd_port(1) !== want) begin
      fails++;
      $display("FAIL zero_reg_after: got %h expected %h", rd_port(1), want);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < NUM_WR; j++) begin
        int a;
        a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, DEPTH - 1));
        set_wr(j, 1'($urandom_range(0, 1)), a, $urandom);
      end
      for (int i = 0; i < NUM_RD; i++) begin
        set_ra(i, ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, DEPTH - 1)));
      end
      run_cycle();
      for (int i = 0; i < NUM_RD; i++) begin
        tests++;
        if (rd_port(i) !== exp_rd[i]) begin
          fails++;
          $display("FAIL random c%0d rd%0d: got %h expected %h", c, i, rd_port(i), exp_rd[i]);
        end
      end
      tests++;
      if (BUSY !== 1'b0) begin
        fails++;
        $display("FAIL random_busy c%0d: got %b expected 0", c, BUSY);
      end
    end
    WE = '0;
  endtask

  task automatic test_mid_clear_reset();
    int n;
    // fill a few registers so a skipped clear would show up
    for (int k = 1; k < 6; k++) begin
      set_wr(0, 1'b1, k, 32'h5000_0000 + 32'(k));
      set_wr(1, 1'b0, 0, 32'h0);
      run_cycle();
    end
    WE = '0;
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    RESET_N = 1'b0;
    tick();
    tests++;
    if (BUSY !== 1'b1 || RD !== '0) begin
      fails++;
      $display("FAIL midclear_reset: got busy %b rd %h expected busy 1 rd 0", BUSY, RD);
    end
    RESET_N = 1'b1;
    n = 0;
    while (BUSY === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (n != DEPTH) begin
      fails++;
      $display("FAIL midclear_busy_len: got %0d cycles expected %0d", n, DEPTH);
    end
    model_clear();
    for (int k = 1; k < 6; k++) begin
      set_ra(0, k);
      set_ra(1, DEPTH - k);
      run_cycle();
      tests++;
      if (rd_port(0) !== exp_rd[0] || rd_port(1) !== exp_rd[1]) begin
        fails++;
        $display("FAIL midclear_cleared a%0d: got %h/%h expected %h/%h", k, rd_port(0), rd_port(1), exp_rd[0], exp_rd[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_bypass();
    test_collision();
    test_zero_reg();
    test_random();
    test_mid_clear_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_register_file_mp
